spi_target_regs: RTL and testbench

Fabric SPI target (responder) that answers an SPI controller on the board's SPI pins and exposes a 16×8 register file to the rest of the design. It is the far end of the hard-IP SPI controller path: the controller drives SCLK/MOSI/CS_N, and this block samples them in the 27 MHz `clk` domain, decodes command and data bytes, and returns register contents on MISO. Register 0 drives control outputs (RGB LED bits). Register 15 is a read-only status input.

---
 rtl/spi_target_pkg.sv | 14 +
 rtl/spi_edge_sync.sv | 44 ++++
 rtl/spi_target_regs.sv | 174 +++++++++++++++++
 tb/tb_spi_target_regs.sv | 222 ++++++++++++++++++++++
 4 files changed

// File: rtl/spi_target_pkg.sv
// spi_target_pkg: frame-state encoding and fixed register addresses shared by the SPI target.
package spi_target_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      CMD  = 2'd1,
      DATA = 2'd2
   } spi_state_t;

   localparam int CMD_RD_BIT  = 7;
   localparam int STATUS_ADDR = 15;
   localparam int CTRL_ADDR   = 0;

endpackage

// File: rtl/spi_edge_sync.sv
// spi_edge_sync: multi-flop synchronizer for one asynchronous pin with registered rise/fall strobes.
// The level output is delayed to line up with the strobes, so level and edge change in the same cycle.
module spi_edge_sync #(
   parameter int   SYNC_STAGES = 2,
   parameter logic RESET_VAL   = 1'b0
) (
   input  logic clk,
   input  logic rst,
   input  logic din,
   output logic level,
   output logic rise,
   output logic fall
);

   logic [SYNC_STAGES-1:0] sync_reg;
   logic                   level_reg;
   logic                   rise_reg;
   logic                   fall_reg;
   logic                   sync_out;

   assign sync_out = sync_reg[SYNC_STAGES-1];

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         sync_reg  <= {SYNC_STAGES{RESET_VAL}};
         level_reg <= RESET_VAL;
         rise_reg  <= 1'b0;
         fall_reg  <= 1'b0;
      end else begin
         sync_reg[0] <= din;
         for (int i = 1; i < SYNC_STAGES; i++) begin
            sync_reg[i] <= sync_reg[i-1];
         end
         level_reg <= sync_out;
         rise_reg  <= sync_out & ~level_reg;
         fall_reg  <= ~sync_out & level_reg;
      end
   end

   assign level = level_reg;
   assign rise  = rise_reg;
   assign fall  = fall_reg;

endmodule

// File: rtl/spi_target_regs.sv
// spi_target_regs: mode-0 SPI target exposing a 16x8 register file (reg 0 = ctrl, reg 15 = status).
// Build option SPI_TARGET_AUTOINC_EN: when defined the address advances after every data byte.
module spi_target_regs
   import spi_target_pkg::*;
#(
   parameter int ADDR_W      = 4,
   parameter int SYNC_STAGES = 2
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              sclk,
   input  logic              mosi,
   input  logic              cs_n,
   output logic              miso_o,
   output logic              miso_oe,
   input  logic [7:0]        status,
   output logic [7:0]        ctrl,
   output logic              wr_stb,
   output logic [ADDR_W-1:0] wr_addr,
   output logic [7:0]        wr_data,
   output logic              busy
);

   localparam int                NUM_REGS = 1 << ADDR_W;
   localparam logic [ADDR_W-1:0] STAT_A   = ADDR_W'(STATUS_ADDR);
   localparam logic [ADDR_W-1:0] CTRL_A   = ADDR_W'(CTRL_ADDR);
`ifdef SPI_TARGET_AUTOINC_EN
   localparam logic [ADDR_W-1:0] ADDR_STEP = ADDR_W'(1);
`else
   localparam logic [ADDR_W-1:0] ADDR_STEP = '0;
`endif

   logic sclk_level, sclk_rise, sclk_fall;
   logic cs_level, cs_rise, cs_fall;
   logic mosi_level, mosi_rise, mosi_fall;
   logic unused_sync;

   spi_edge_sync #(.SYNC_STAGES(SYNC_STAGES), .RESET_VAL(1'b0)) u_sclk_sync (
      .clk   (clk),
      .rst   (rst),
      .din   (sclk),
      .level (sclk_level),
      .rise  (sclk_rise),
      .fall  (sclk_fall)
   );

   spi_edge_sync #(.SYNC_STAGES(SYNC_STAGES), .RESET_VAL(1'b1)) u_cs_sync (
      .clk   (clk),
      .rst   (rst),
      .din   (cs_n),
      .level (cs_level),
      .rise  (cs_rise),
      .fall  (cs_fall)
   );

   spi_edge_sync #(.SYNC_STAGES(SYNC_STAGES), .RESET_VAL(1'b0)) u_mosi_sync (
      .clk   (clk),
      .rst   (rst),
      .din   (mosi),
      .level (mosi_level),
      .rise  (mosi_rise),
      .fall  (mosi_fall)
   );

   assign unused_sync = &{1'b0, sclk_level, cs_rise, mosi_rise, mosi_fall};

   spi_state_t        state_reg, state_next;
   logic [2:0]        bit_cnt_reg;
   logic [6:0]        rx_shift_reg;
   logic [7:0]        tx_shift_reg;
   logic [ADDR_W-1:0] addr_reg;
   logic              rd_frame_reg;
   logic [7:0]        regs [NUM_REGS];
   logic              wr_stb_reg;
   logic [ADDR_W-1:0] wr_addr_reg;
   logic [7:0]        wr_data_reg;

   logic              active;
   logic              byte_done;
   logic [7:0]        rx_byte;
   logic [7:0]        rd_value;
   logic [ADDR_W-1:0] cmd_addr;
   logic [ADDR_W-1:0] rd_sel;

   assign active    = (state_reg != IDLE) && !cs_level;
   assign rx_byte   = {rx_shift_reg, mosi_level};
   assign byte_done = active && sclk_rise && (bit_cnt_reg == 3'd7);
   assign cmd_addr  = rx_byte[ADDR_W-1:0];
   assign rd_sel    = (state_reg == CMD) ? cmd_addr : addr_reg;
   assign rd_value  = (rd_sel == STAT_A) ? status : regs[rd_sel];

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_reg <= IDLE;
      end else begin
         state_reg <= state_next;
      end
   end

   always_comb begin
      state_next = state_reg;
      case (state_reg)
         IDLE:    if (cs_fall) state_next = CMD;
         CMD:     if (byte_done) state_next = DATA;
         DATA:    state_next = DATA;
         default: state_next = IDLE;
      endcase
      if (cs_level) state_next = IDLE;
   end

   // The fall right after a byte boundary (bit count back at 0) must not shift,
   // otherwise the freshly loaded MSB would be lost before the controller samples it.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         bit_cnt_reg  <= '0;
         rx_shift_reg <= '0;
         tx_shift_reg <= '0;
         addr_reg     <= '0;
         rd_frame_reg <= 1'b0;
         wr_stb_reg   <= 1'b0;
         wr_addr_reg  <= '0;
         wr_data_reg  <= '0;
         for (int i = 0; i < NUM_REGS; i++) begin
            regs[i] <= '0;
         end
      end else begin
         wr_stb_reg <= 1'b0;
         if (!active) begin
            bit_cnt_reg  <= '0;
            tx_shift_reg <= '0;
            rd_frame_reg <= 1'b0;
         end else begin
            if (sclk_rise) begin
               rx_shift_reg <= rx_byte[6:0];
               bit_cnt_reg  <= bit_cnt_reg + 3'd1;
            end
            if (sclk_fall && rd_frame_reg && (bit_cnt_reg != 3'd0)) begin
               tx_shift_reg <= {tx_shift_reg[6:0], 1'b0};
            end
            if (byte_done) begin
               if (state_reg == CMD) begin
                  rd_frame_reg <= rx_byte[CMD_RD_BIT];
                  if (rx_byte[CMD_RD_BIT]) begin
                     tx_shift_reg <= rd_value;
                     addr_reg     <= cmd_addr + ADDR_STEP;
                  end else begin
                     addr_reg <= cmd_addr;
                  end
               end else if (rd_frame_reg) begin
                  tx_shift_reg <= rd_value;
                  addr_reg     <= addr_reg + ADDR_STEP;
               end else begin
                  if (addr_reg != STAT_A) begin
                     regs[addr_reg] <= rx_byte;
                     wr_stb_reg     <= 1'b1;
                     wr_addr_reg    <= addr_reg;
                     wr_data_reg    <= rx_byte;
                  end
                  addr_reg <= addr_reg + ADDR_STEP;
               end
            end
         end
      end
   end

   assign miso_o  = tx_shift_reg[7];
   assign miso_oe = (state_reg != IDLE);
   assign busy    = ~cs_level;
   assign ctrl    = regs[CTRL_A];
   assign wr_stb  = wr_stb_reg;
   assign wr_addr = wr_addr_reg;
   assign wr_data = wr_data_reg;

endmodule

// File: tb/tb_spi_target_regs.sv
// tb_spi_target_regs: directed SPI frames checked against a register model and write/read scoreboards.
`timescale 1ns/1ps
module tb_spi_target_regs;

   localparam int HALF = 8;
`ifdef SPI_TARGET_AUTOINC_EN
   localparam logic [3:0] STEP = 4'd1;
`else
   localparam logic [3:0] STEP = 4'd0;
`endif

   logic       clk = 1'b0;
   logic       rst = 1'b0;
   logic       sclk = 1'b0;
   logic       mosi = 1'b0;
   logic       cs_n = 1'b1;
   logic [7:0] status = 8'h00;
   logic       miso_o, miso_oe, wr_stb, busy;
   logic [7:0] ctrl, wr_data;
   logic [3:0] wr_addr;

   int checks = 0;
   int passes = 0;
   int fails  = 0;

   logic [7:0]  model [16];
   logic [11:0] wr_q [$];
   logic [7:0]  rd_q [$];
   logic [11:0] wr_exp;
   logic [3:0]  last_wa = 4'd0;
   logic [7:0]  last_wd = 8'h00;

   always #5 clk = ~clk;

   spi_target_regs dut (
      .clk     (clk),
      .rst     (rst),
      .sclk    (sclk),
      .mosi    (mosi),
      .cs_n    (cs_n),
      .miso_o  (miso_o),
      .miso_oe (miso_oe),
      .status  (status),
      .ctrl    (ctrl),
      .wr_stb  (wr_stb),
      .wr_addr (wr_addr),
      .wr_data (wr_data),
      .busy    (busy)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) passes++;
      else begin
         fails++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   // Every strobe must match the oldest pending write; ctrl must follow a reg-0 write in the same cycle.
   always @(negedge clk) begin
      if (wr_stb) begin
         chk("wr_stb_pending", 32'(wr_q.size() > 0), 32'd1);
         if (wr_q.size() > 0) begin
            wr_exp = wr_q.pop_front();
            chk("wr_stb_addr_data", {20'd0, wr_addr, wr_data}, {20'd0, wr_exp});
            if (wr_exp[11:8] == 4'd0) chk("ctrl_on_stb", {24'd0, ctrl}, {24'd0, wr_exp[7:0]});
         end
      end
   end

   task automatic spi_bits(input logic [7:0] tx, input int n, output logic [7:0] rx);
      rx = 8'h00;
      for (int i = 0; i < n; i++) begin
         mosi = tx[7-i];
         repeat (HALF) @(negedge clk);
         rx = {rx[6:0], miso_o};
         sclk = 1'b1;
         repeat (HALF) @(negedge clk);
         sclk = 1'b0;
      end
   endtask

   task automatic frame_start();
      @(negedge clk);
      cs_n = 1'b0;
      repeat (6) @(negedge clk);
   endtask

   task automatic frame_end();
      repeat (6) @(negedge clk);
      cs_n = 1'b1;
      repeat (10) @(negedge clk);
   endtask

   task automatic wr_frame(input logic [7:0] cmd, input int n,
                           input logic [7:0] d0, input logic [7:0] d1, input logic [7:0] d2);
      logic [3:0] a;
      logic [7:0] d;
      logic [7:0] rx;
      a = cmd[3:0];
      frame_start();
      spi_bits(cmd, 8, rx);
      for (int k = 0; k < n; k++) begin
         d = (k == 0) ? d0 : ((k == 1) ? d1 : d2);
         if (a != 4'd15) begin
            model[a] = d;
            wr_q.push_back({a, d});
            last_wa = a;
            last_wd = d;
         end
         a = a + STEP;
         spi_bits(d, 8, rx);
      end
      frame_end();
      chk("wr_q_drained", wr_q.size(), 32'd0);
      $display("write frame cmd=0x%02h data_bytes=%0d ctrl=0x%02h", cmd, n, ctrl);
   endtask

   task automatic rd_frame(input logic [7:0] cmd, input int n);
      logic [3:0] a;
      logic [7:0] rx;
      logic [7:0] e;
      a = cmd[3:0];
      chk("miso_oe_before", {31'd0, miso_oe}, 32'd0);
      frame_start();
      spi_bits(cmd, 8, rx);
      chk("miso_during_cmd", {24'd0, rx}, 32'd0);
      chk("miso_oe_in_frame", {31'd0, miso_oe}, 32'd1);
      chk("busy_in_frame", {31'd0, busy}, 32'd1);
      for (int k = 0; k < n; k++) begin
         rd_q.push_back((a == 4'd15) ? status : model[a]);
         a = a + STEP;
         spi_bits(8'hFF, 8, rx);
         e = rd_q.pop_front();
         chk("read_byte", {24'd0, rx}, {24'd0, e});
         $display("read frame cmd=0x%02h byte%0d got=0x%02h", cmd, k, rx);
      end
      frame_end();
      chk("miso_oe_after", {31'd0, miso_oe}, 32'd0);
   endtask

   task automatic check_reset_outputs(input string phase);
      chk({phase, "_miso_o"}, {31'd0, miso_o}, 32'd0);
      chk({phase, "_miso_oe"}, {31'd0, miso_oe}, 32'd0);
      chk({phase, "_ctrl"}, {24'd0, ctrl}, 32'd0);
      chk({phase, "_wr_stb"}, {31'd0, wr_stb}, 32'd0);
      chk({phase, "_wr_addr"}, {28'd0, wr_addr}, 32'd0);
      chk({phase, "_wr_data"}, {24'd0, wr_data}, 32'd0);
      chk({phase, "_busy"}, {31'd0, busy}, 32'd0);
   endtask

   initial begin
      logic [7:0] rx;
      for (int i = 0; i < 16; i++) model[i] = 8'h00;

      // Power-on reset
      repeat (4) @(negedge clk);
      check_reset_outputs("reset");
      rst = 1'b1;
      repeat (5) @(negedge clk);

      // Single write to reg 0
      wr_frame(8'h00, 1, 8'h05, 8'h00, 8'h00);
      chk("ctrl_after_write", {24'd0, ctrl}, 32'h05);
      chk("wr_addr_last", {28'd0, wr_addr}, {28'd0, last_wa});
      chk("wr_data_last", {24'd0, wr_data}, {24'd0, last_wd});

      // Burst write starting at 14 (passes over the status address)
      wr_frame(8'h0E, 3, 8'hAA, 8'hBB, 8'hCC);
      chk("ctrl_after_burst", {24'd0, ctrl}, {24'd0, model[0]});
      chk("wr_addr_burst", {28'd0, wr_addr}, {28'd0, last_wa});
      chk("wr_data_burst", {24'd0, wr_data}, {24'd0, last_wd});

      // Burst read starting at 14, then status and ctrl directly
      status = 8'h3C;
      rd_frame(8'h8E, 2);
      rd_frame(8'h8F, 1);
      rd_frame(8'h80, 1);

      // Abort mid-byte must not write
      wr_frame(8'h03, 1, 8'h77, 8'h00, 8'h00);
      frame_start();
      spi_bits(8'h03, 8, rx);
      spi_bits(8'hEE, 5, rx);
      frame_end();
      $display("abort frame cmd=0x03 after 5 data bits");
      chk("abort_miso_oe", {31'd0, miso_oe}, 32'd0);
      chk("abort_busy", {31'd0, busy}, 32'd0);
      chk("abort_wr_q", wr_q.size(), 32'd0);
      rd_frame(8'h83, 1);

      // Reset in the middle of a read frame
      frame_start();
      spi_bits(8'h8E, 8, rx);
      spi_bits(8'hFF, 3, rx);
      @(negedge clk);
      rst = 1'b0;
      #1;
      check_reset_outputs("midreset");
      $display("reset asserted mid-read");
      cs_n = 1'b1;
      sclk = 1'b0;
      for (int i = 0; i < 16; i++) model[i] = 8'h00;
      repeat (3) @(negedge clk);
      rst = 1'b1;
      repeat (5) @(negedge clk);
      rd_frame(8'h80, 1);
      wr_frame(8'h01, 1, 8'h5A, 8'h00, 8'h00);
      rd_frame(8'h81, 1);

      // Two data bytes to reg 2: address fixed or auto-incrementing depending on build
      wr_frame(8'h03, 1, 8'h99, 8'h00, 8'h00);
      wr_frame(8'h02, 2, 8'h11, 8'h22, 8'h00);
      rd_frame(8'h82, 1);
      rd_frame(8'h83, 1);

      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end

endmodule
